// File: rtl/mac_seq.sv
// Sequencer that drives one external MAC: clear, stream LEN operand pairs,
// wait for the pipeline to drain, then hand the accumulator downstream.
// Optional shadow-accumulator overflow flag: define MAC_SEQ_OVF_EN.
module mac_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_enable,
  output logic              reset_acc,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [LEN_W-1:0]   r_remaining;
  logic [DATA_W-1:0]  r_mac_a;
  logic [DATA_W-1:0]  r_mac_b;
  logic               r_mac_enable;
  logic [ACC_W-1:0]   r_out_data;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_last_pair;

  assign w_in_hs     = (r_state == S_ACCUM) && in_valid;
  assign w_out_hs    = (r_state == S_OUTPUT) && out_ready;
  assign w_last_pair = (r_remaining == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = (r_remaining != '0) ? S_ACCUM : S_DRAIN1;
      S_ACCUM:  if (w_in_hs && w_last_pair) w_state_next = S_DRAIN1;
      S_DRAIN1: w_state_next = S_DRAIN2;
      S_DRAIN2: w_state_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_ACCUM);
    reset_acc = (r_state == S_CLEAR);
    out_valid = (r_state == S_OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_remaining <= len;
    end else if (w_in_hs) begin
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  // The enable mirrors the handshake one cycle late, so a stalled cycle never re-adds a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mac_a      <= '0;
      r_mac_b      <= '0;
      r_mac_enable <= 1'b0;
    end else begin
      r_mac_enable <= w_in_hs;
      if (w_in_hs) begin
        r_mac_a <= in_a;
        r_mac_b <= in_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (r_state == S_DRAIN2) begin
      r_out_data <= mac_acc;
    end
  end

  assign mac_a      = r_mac_a;
  assign mac_b      = r_mac_b;
  assign mac_enable = r_mac_enable;
  assign out_data   = r_out_data;

`ifdef MAC_SEQ_OVF_EN
  localparam int SHADOW_W = 2 * DATA_W + LEN_W;

  logic [SHADOW_W-1:0]   r_shadow;
  logic [2*DATA_W-1:0]   w_prod;
  logic                  w_shadow_ovf;
  logic                  r_ovf;

  assign w_prod       = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
  // Any bit at or above ACC_W means the exact sum exceeded what the MAC can hold.
  assign w_shadow_ovf = |(r_shadow >> ACC_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (r_state == S_CLEAR) begin
      r_shadow <= '0;
    end else if (w_in_hs) begin
      r_shadow <= r_shadow + {{LEN_W{1'b0}}, w_prod};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_DRAIN2) begin
      r_ovf <= w_shadow_ovf;
    end else if (w_out_hs) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_ovf = r_ovf;
`else
  logic w_unused_out_hs;

  assign w_unused_out_hs = w_out_hs;
  assign out_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural MAC (clear / enable-accumulate, wraps at 8 bits)
// that is deliberately not reset by rst_n.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_enable;
  logic        reset_acc;
  logic [7:0]  mac_acc = 8'h5A;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MAC_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mac_seq #(.DATA_W(8), .ACC_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_enable(mac_enable), .reset_acc(reset_acc),
    .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always @(posedge clk) begin
    if (reset_acc)       mac_acc <= 8'd0;
    else if (mac_enable) mac_acc <= mac_acc + 8'(mac_a * mac_b);
  end

  typedef struct {
    string            name;
    int               n;
    logic [7:0][7:0]  av;
    logic [7:0][7:0]  bv;
    bit               gaps;
    int               hold;
    bit               stray;
    logic [7:0]       exp_d;
    bit               exp_o;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [7:0][7:0] pk(input logic [7:0] p0, input logic [7:0] p1,
                                         input logic [7:0] p2, input logic [7:0] p3);
    return {32'd0, p3, p2, p1, p0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the output handshake.
  task automatic run_job(input string name, input int n, input logic [7:0][7:0] av,
                         input logic [7:0][7:0] bv, input bit gaps, input int hold,
                         input bit stray, input logic [7:0] exp_d, input bit exp_o);
    int idx = 0, last_hs = -1, t_valid = -1, pulses = 0, ready_seen = 0, held = 0;
    bit done = 1'b0;
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy_after_start"}, int'(busy), 1);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (reset_acc) pulses++;
      if (in_ready) ready_seen++;
      start = stray && (cyc == 3);
      len   = stray ? 8'd9 : 8'(n);
      if (idx < n && (!gaps || (cyc % 2 == 0))) begin
        in_valid = 1'b1;
        in_a = av[idx];
        in_b = bv[idx];
        if (in_ready) begin
          last_hs = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
        in_a = 8'hEE;
        in_b = 8'hEE;
      end
      if (out_valid) begin
        if (t_valid < 0) begin
          t_valid = cyc;
          if (n > 0) chk({name, " latency"}, t_valid - last_hs, 3);
        end
        if (held < hold) begin
          out_ready = 1'b0;
          chk({name, " held_data"}, int'(out_data), int'(exp_d));
          held++;
        end else begin
          out_ready = 1'b1;
          chk({name, " out_data"}, int'(out_data), int'(exp_d));
          chk({name, " out_ovf"}, int'(out_ovf), int'(exp_o & OVF_ON));
          done = 1'b1;
        end
      end
    end
    chk({name, " completed"}, int'(done), 1);
    chk({name, " pairs"}, idx, n);
    chk({name, " reset_acc_pulses"}, pulses, 1);
    if (n == 0) chk({name, " in_ready_seen"}, ready_seen, 0);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({name, " busy_after"}, int'(busy), 0);
    chk({name, " out_valid_after"}, int'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{"len3_basic", 3, pk(1, 3, 5, 0), pk(2, 4, 6, 0), 1'b0, 0, 1'b0, 8'd44, 1'b0};
    vecs[1] = '{"len2_wrap", 2, pk(16, 1, 0, 0), pk(16, 1, 0, 0), 1'b0, 0, 1'b0, 8'd1, 1'b1};
    vecs[2] = '{"len0", 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b0, 0, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{"len4_gaps_hold", 4, pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b1, 5, 1'b1, 8'd24, 1'b0};
    vecs[4] = '{"len3_max", 3, pk(255, 255, 255, 0), pk(255, 255, 255, 0), 1'b0, 0, 1'b0, 8'd3, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset mac_enable", int'(mac_enable), 0);
    chk("reset reset_acc", int'(reset_acc), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_ovf", int'(out_ovf), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset mac_a", int'({mac_a, mac_b}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].name, vecs[i].n, vecs[i].av, vecs[i].bv, vecs[i].gaps,
              vecs[i].hold, vecs[i].stray, vecs[i].exp_d, vecs[i].exp_o);
      @(negedge clk);
      chk({vecs[i].name, " idle_stays"}, int'(busy), 0);
    end

    // Abort a len=5 job after two handshakes.
    begin
      int hs = 0;
      start = 1'b1;
      len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_a = 8'd9;
      in_b = 8'd9;
      for (int c = 0; c < 20 && hs < 2; c++) begin
        @(negedge clk);
        if (in_ready) hs++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort pre busy", int'(busy), 1);
      chk("abort pre mac_enable", int'(mac_enable), 1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", int'(busy), 0);
      chk("abort in_ready", int'(in_ready), 0);
      chk("abort mac_enable", int'(mac_enable), 0);
      chk("abort mac_a", int'({mac_a, mac_b}), 0);
      chk("abort out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job("after_abort", 1, pk(7, 0, 0, 0), pk(7, 0, 0, 0), 1'b0, 0, 1'b0, 8'd49, 1'b0);
    end

    run_job("b2b_first", 2, pk(1, 1, 0, 0), pk(1, 1, 0, 0), 1'b0, 0, 1'b0, 8'd2, 1'b0);
    run_job("b2b_second", 2, pk(2, 2, 0, 0), pk(2, 2, 0, 0), 1'b0, 0, 1'b0, 8'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
